multicycle_control_unit: RTL and testbench

Multi-cycle successor to the single-cycle control unit. An FSM sequences each instruction through fetch, decode, execute, memory and write-back over 3–5 cycles. It drives a shared-memory datapath with a ready handshake, so memory wait states are supported. It extends the decoded set to I-type ALU ops, BNE and JAL, and adds illegal-instruction trapping and a retire strobe.

---
 rtl/cpu_pkg.sv | 61 ++++++
 rtl/alu_decoder.sv | 28 ++
 rtl/multicycle_control_unit.sv | 167 ++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle control unit and its datapath:
// opcodes, ALU operations, FSM states and datapath mux selects.
package cpu_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd4,
        ALU_XOR = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7,
        ALU_SRA = 4'd8
    } alu_op_e;

    typedef enum logic [3:0] {
        S_BOOT,
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_ALU,
        S_WB_MEM,
        S_BRANCH,
        S_JAL,
        S_TRAP
    } state_e;

    typedef enum logic [1:0] {
        PC_SRC_ALU    = 2'd0,
        PC_SRC_ALUOUT = 2'd1,
        PC_SRC_RSVD   = 2'd2
    } pc_src_e;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'd0,
        SRCB_FOUR = 2'd1,
        SRCB_IMM  = 2'd2
    } alu_src_b_e;

    typedef enum logic [1:0] {
        WB_ALUOUT = 2'd0,
        WB_MDR    = 2'd1,
        WB_PC     = 2'd2
    } wb_sel_e;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode from funct fields for R- and I-type ops.
module alu_decoder
    import cpu_pkg::*;
(
    input  logic       is_rtype_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7_5_i,
    output alu_op_e    alu_op_o
);

    // For I-type, funct7_5 is an immediate bit except on shifts, so it only
    // qualifies the op for R-type arithmetic and for the shift encodings.
    always_comb begin
        alu_op_o = ALU_ADD;
        unique case (funct3_i)
            3'b000: alu_op_o = (is_rtype_i && funct7_5_i) ? ALU_SUB : ALU_ADD;
            3'b001: alu_op_o = funct7_5_i ? ALU_ADD : ALU_SLL;
            3'b010: alu_op_o = (is_rtype_i && funct7_5_i) ? ALU_ADD : ALU_SLT;
            3'b011: alu_op_o = ALU_ADD;
            3'b100: alu_op_o = (is_rtype_i && funct7_5_i) ? ALU_ADD : ALU_XOR;
            3'b101: alu_op_o = funct7_5_i ? ALU_SRA : ALU_SRL;
            3'b110: alu_op_o = (is_rtype_i && funct7_5_i) ? ALU_ADD : ALU_OR;
            3'b111: alu_op_o = (is_rtype_i && funct7_5_i) ? ALU_ADD : ALU_AND;
            default: alu_op_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FSM controller: sequences fetch/decode/execute/memory/write-back
// against a ready-handshaked shared memory, with illegal-instruction trapping.
module multicycle_control_unit
    import cpu_pkg::*;
#(
    parameter int unsigned ALU_OP_W = 4,
    parameter bit          EN_JAL   = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic                funct7_5,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                iord,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                reg_write,
    output logic [1:0]          wb_sel,
    output logic                retire,
    output logic                trap
);

    state_e  state_q, state_d;
    alu_op_e dec_op;
    alu_op_e alu_op_sel;

    alu_decoder u_alu_decoder (
        .is_rtype_i (state_q == S_EXEC_R),
        .funct3_i   (funct3),
        .funct7_5_i (funct7_5),
        .alu_op_o   (dec_op)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_BOOT;
        else        state_q <= state_d;
    end

    assign alu_op = ALU_OP_W'(alu_op_sel);

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RS2;
        alu_op_sel = ALU_ADD;
        reg_write  = 1'b0;
        wb_sel     = WB_ALUOUT;
        retire     = 1'b0;
        trap       = 1'b0;

        unique case (state_q)
            S_BOOT: state_d = S_FETCH;

            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end

            S_DECODE: begin
                alu_src_b = SRCB_IMM;
                unique case (opcode)
                    OP_RTYPE:           state_d = S_EXEC_R;
                    OP_ITYPE:           state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
                    OP_BRANCH: state_d = (funct3 == F3_BEQ || funct3 == F3_BNE)
                                         ? S_BRANCH : S_TRAP;
                    OP_JAL:    state_d = EN_JAL ? S_JAL : S_TRAP;
                    default:   state_d = S_TRAP;
                endcase
            end

            S_EXEC_R: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_RS2;
                alu_op_sel = dec_op;
                state_d    = S_WB_ALU;
            end

            S_EXEC_I: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                alu_op_sel = dec_op;
                state_d    = S_WB_ALU;
            end

            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end

            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_d = S_WB_MEM;
            end

            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end

            S_WB_ALU: begin
                reg_write = 1'b1;
                wb_sel    = WB_ALUOUT;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end

            S_WB_MEM: begin
                reg_write = 1'b1;
                wb_sel    = WB_MDR;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end

            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_RS2;
                alu_op_sel = ALU_SUB;
                pc_src     = PC_SRC_ALUOUT;
                pc_write   = (funct3 == F3_BNE) ? ~zero : zero;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end

            // PC already holds PC+4 after FETCH, so the link value is the PC itself.
            S_JAL: begin
                reg_write = 1'b1;
                wb_sel    = WB_PC;
                pc_write  = 1'b1;
                pc_src    = PC_SRC_ALUOUT;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end

            S_TRAP: trap = 1'b1;

            default: state_d = S_BOOT;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed-vector bench for multicycle_control_unit: per-cycle output checks.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       funct7_5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic       mem_req, mem_we, iord, ir_write, pc_write, alu_src_a, reg_write, retire, trap;
    logic [1:0] pc_src, alu_src_b, wb_sel;
    logic [3:0] alu_op;

    logic       n_mem_req, n_mem_we, n_iord, n_ir_write, n_pc_write, n_alu_src_a;
    logic       n_reg_write, n_retire, n_trap;
    logic [1:0] n_pc_src, n_alu_src_b, n_wb_sel;
    logic [3:0] n_alu_op;

    int n_checks = 0;
    int n_errors = 0;
    int retire_cnt = 0;

    always #5 clk = ~clk;

    multicycle_control_unit #(.ALU_OP_W(4), .EN_JAL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write), .wb_sel(wb_sel),
        .retire(retire), .trap(trap)
    );

    multicycle_control_unit #(.ALU_OP_W(4), .EN_JAL(1'b0)) dut_nj (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(n_mem_req), .mem_we(n_mem_we),
        .iord(n_iord), .ir_write(n_ir_write), .pc_write(n_pc_write), .pc_src(n_pc_src),
        .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b), .alu_op(n_alu_op),
        .reg_write(n_reg_write), .wb_sel(n_wb_sel), .retire(n_retire), .trap(n_trap)
    );

    logic [18:0] obs, obs_nj;
    assign obs    = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
                     alu_src_b, alu_op, reg_write, wb_sel, retire, trap};
    assign obs_nj = {n_mem_req, n_mem_we, n_iord, n_ir_write, n_pc_write, n_pc_src,
                     n_alu_src_a, n_alu_src_b, n_alu_op, n_reg_write, n_wb_sel, n_retire, n_trap};

    always @(posedge clk) if (retire) retire_cnt <= retire_cnt + 1;

    function automatic logic [18:0] pk(input logic mreq, input logic mwe, input logic ird,
                                       input logic irw, input logic pcw, input logic [1:0] pcs,
                                       input logic asa, input logic [1:0] asb,
                                       input logic [3:0] aop, input logic rw,
                                       input logic [1:0] wbs, input logic ret, input logic trp);
        return {mreq, mwe, ird, irw, pcw, pcs, asa, asb, aop, rw, wbs, ret, trp};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive handshake inputs for the current cycle, check outputs, advance one clock.
    task automatic step(input logic mr, input logic z, input logic [18:0] exp, input string tag);
        mem_ready = mr;
        zero      = z;
        #1;
        check(tag, 32'(obs), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic set_insn(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        opcode   = op;
        funct3   = f3;
        funct7_5 = f7;
    endtask

    logic [18:0] e_zero, e_fetch_w, e_fetch_r, e_decode, e_wb_alu, e_mem_addr, e_mem_rd;
    logic [18:0] e_wb_mem, e_trap;

    initial begin
        e_zero     = pk(0,0,0,0,0,2'd0,0,2'd0,4'd0,0,2'd0,0,0);
        e_fetch_w  = pk(1,0,0,0,0,2'd0,0,2'd1,4'd0,0,2'd0,0,0);
        e_fetch_r  = pk(1,0,0,1,1,2'd0,0,2'd1,4'd0,0,2'd0,0,0);
        e_decode   = pk(0,0,0,0,0,2'd0,0,2'd2,4'd0,0,2'd0,0,0);
        e_wb_alu   = pk(0,0,0,0,0,2'd0,0,2'd0,4'd0,1,2'd0,1,0);
        e_mem_addr = pk(0,0,0,0,0,2'd0,1,2'd2,4'd0,0,2'd0,0,0);
        e_mem_rd   = pk(1,0,1,0,0,2'd0,0,2'd0,4'd0,0,2'd0,0,0);
        e_wb_mem   = pk(0,0,0,0,0,2'd0,0,2'd0,4'd0,1,2'd1,1,0);
        e_trap     = pk(0,0,0,0,0,2'd0,0,2'd0,4'd0,0,2'd0,0,1);

        // Power-on reset, then one BOOT cycle before the first fetch
        #1 rst_n = 1'b0;
        #1 check("reset_state", 32'(obs), 32'(e_zero));
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b1, 1'b0, e_zero, "boot");

        // Reset asserted mid-request drops everything immediately
        mem_ready = 1'b0;
        #1 check("fetch_req", 32'(obs), 32'(e_fetch_w));
        rst_n = 1'b0;
        #1 check("reset_mid_fetch", 32'(obs), 32'(e_zero));
        #1 rst_n = 1'b1;
        step(1'b1, 1'b0, e_zero, "boot_again");

        // ADD: 4 cycles
        set_insn(7'b0110011, 3'b000, 1'b0);
        step(1'b1, 1'b0, e_fetch_r, "add_fetch");
        step(1'b1, 1'b0, e_decode, "add_decode");
        step(1'b1, 1'b0, pk(0,0,0,0,0,2'd0,1,2'd0,4'd0,0,2'd0,0,0), "add_exec");
        step(1'b1, 1'b0, e_wb_alu, "add_wb");

        // LW with 2 fetch waits and 3 read waits: 10 cycles
        set_insn(7'b0000011, 3'b010, 1'b0);
        step(1'b0, 1'b0, e_fetch_w, "lw_fetch_w0");
        step(1'b0, 1'b0, e_fetch_w, "lw_fetch_w1");
        step(1'b1, 1'b0, e_fetch_r, "lw_fetch");
        step(1'b1, 1'b0, e_decode, "lw_decode");
        step(1'b1, 1'b0, e_mem_addr, "lw_addr");
        step(1'b0, 1'b0, e_mem_rd, "lw_rd_w0");
        step(1'b0, 1'b0, e_mem_rd, "lw_rd_w1");
        step(1'b0, 1'b0, e_mem_rd, "lw_rd_w2");
        step(1'b1, 1'b0, e_mem_rd, "lw_rd");
        step(1'b1, 1'b0, e_wb_mem, "lw_wb");

        // SW with one write wait: retire only on the ready cycle
        set_insn(7'b0100011, 3'b010, 1'b0);
        step(1'b1, 1'b0, e_fetch_r, "sw_fetch");
        step(1'b1, 1'b0, e_decode, "sw_decode");
        step(1'b1, 1'b0, e_mem_addr, "sw_addr");
        step(1'b0, 1'b0, pk(1,1,1,0,0,2'd0,0,2'd0,4'd0,0,2'd0,0,0), "sw_wr_wait");
        step(1'b1, 1'b0, pk(1,1,1,0,0,2'd0,0,2'd0,4'd0,0,2'd0,1,0), "sw_wr");

        // BNE not taken / taken, BEQ taken
        set_insn(7'b1100011, 3'b001, 1'b0);
        step(1'b1, 1'b1, e_fetch_r, "bne_nt_fetch");
        step(1'b1, 1'b1, e_decode, "bne_nt_decode");
        step(1'b1, 1'b1, pk(0,0,0,0,0,2'd1,1,2'd0,4'd1,0,2'd0,1,0), "bne_nt_branch");
        step(1'b1, 1'b0, e_fetch_r, "bne_t_fetch");
        step(1'b1, 1'b0, e_decode, "bne_t_decode");
        step(1'b1, 1'b0, pk(0,0,0,0,1,2'd1,1,2'd0,4'd1,0,2'd0,1,0), "bne_t_branch");
        set_insn(7'b1100011, 3'b000, 1'b0);
        step(1'b1, 1'b1, e_fetch_r, "beq_fetch");
        step(1'b1, 1'b1, e_decode, "beq_decode");
        step(1'b1, 1'b1, pk(0,0,0,0,1,2'd1,1,2'd0,4'd1,0,2'd0,1,0), "beq_t_branch");

        // SUB (R-type, funct7_5=1)
        set_insn(7'b0110011, 3'b000, 1'b1);
        step(1'b1, 1'b0, e_fetch_r, "sub_fetch");
        step(1'b1, 1'b0, e_decode, "sub_decode");
        step(1'b1, 1'b0, pk(0,0,0,0,0,2'd0,1,2'd0,4'd1,0,2'd0,0,0), "sub_exec");
        step(1'b1, 1'b0, e_wb_alu, "sub_wb");

        // SRAI
        set_insn(7'b0010011, 3'b101, 1'b1);
        step(1'b1, 1'b0, e_fetch_r, "srai_fetch");
        step(1'b1, 1'b0, e_decode, "srai_decode");
        step(1'b1, 1'b0, pk(0,0,0,0,0,2'd0,1,2'd2,4'd8,0,2'd0,0,0), "srai_exec");
        step(1'b1, 1'b0, e_wb_alu, "srai_wb");

        // ADDI with immediate bit 30 set stays ADD
        set_insn(7'b0010011, 3'b000, 1'b1);
        step(1'b1, 1'b0, e_fetch_r, "addi_fetch");
        step(1'b1, 1'b0, e_decode, "addi_decode");
        step(1'b1, 1'b0, pk(0,0,0,0,0,2'd0,1,2'd2,4'd0,0,2'd0,0,0), "addi_exec");
        step(1'b1, 1'b0, e_wb_alu, "addi_wb");

        // JAL: decoded when enabled, traps when disabled
        set_insn(7'b1101111, 3'b000, 1'b0);
        step(1'b1, 1'b0, e_fetch_r, "jal_fetch");
        step(1'b1, 1'b0, e_decode, "jal_decode");
        mem_ready = 1'b1;
        #1;
        check("jal_nj_trap", 32'(obs_nj), 32'(e_trap));
        step(1'b1, 1'b0, pk(0,0,0,0,1,2'd1,0,2'd0,4'd0,1,2'd2,1,0), "jal_exec");

        // Illegal opcode: trap from cycle 3, ready ignored, no retire
        set_insn(7'b1110011, 3'b000, 1'b0);
        step(1'b1, 1'b0, e_fetch_r, "ill_fetch");
        step(1'b1, 1'b0, e_decode, "ill_decode");
        for (int unsigned i = 0; i < 4; i++) step(1'b1, 1'b0, e_trap, "ill_trap_hold");
        check("nj_trap_hold", 32'(obs_nj), 32'(e_trap));
        check("retire_count", 32'(retire_cnt), 32'd10);

        // Only reset leaves TRAP
        rst_n = 1'b0;
        #1;
        check("trap_reset", 32'(obs), 32'(e_zero));
        check("nj_trap_reset", 32'(obs_nj), 32'(e_zero));
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, 1'b0, e_fetch_w, "post_reset_fetch");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
